// File: rtl/dma_wr_req_arbiter.sv
// Packet-granular round-robin arbiter sharing one 512-bit DMA write request
// channel between NUM_REQ requesters; the grant is held from first beat to last.
module dma_wr_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_enable,
    input  logic [NUM_REQ-1:0]     dma_wr_req_in_valid,
    input  logic [NUM_REQ*128-1:0] dma_wr_req_in_head,
    input  logic [NUM_REQ*512-1:0] dma_wr_req_in_data,
    input  logic [NUM_REQ-1:0]     dma_wr_req_in_last,
    output logic [NUM_REQ-1:0]     dma_wr_req_in_ready,
    output logic                   dma_wr_req_out_valid,
    output logic [127:0]           dma_wr_req_out_head,
    output logic [511:0]           dma_wr_req_out_data,
    output logic                   dma_wr_req_out_last,
    input  logic                   dma_wr_req_out_ready,
    output logic [SRC_W-1:0]       dma_wr_req_out_src,
    output logic                   arb_busy
);

    localparam logic [0:0]       ARB_S     = 1'b0;
    localparam logic [0:0]       BUSY_S    = 1'b1;
    localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

    logic [0:0]         state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic               sel_found;
    logic [SRC_W-1:0]   sel_idx;
    logic [SRC_W:0]     scan_idx;

    logic               g_valid;
    logic               g_last;
    logic [127:0]       g_head;
    logic [511:0]       g_data;
    logic               pkt_done;

    assign eligible = dma_wr_req_in_valid & req_enable;

    // First eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!sel_found && eligible[scan_idx[SRC_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_head  = '0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == SRC_W'(i)) begin
                g_valid = dma_wr_req_in_valid[i];
                g_last  = dma_wr_req_in_last[i];
                g_head  = dma_wr_req_in_head[128*i +: 128];
                g_data  = dma_wr_req_in_data[512*i +: 512];
            end
        end
    end

    assign pkt_done = (state_q == BUSY_S) && g_valid && dma_wr_req_out_ready && g_last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_S) begin
            if (sel_found) begin
                grant_d = sel_idx;
                state_d = BUSY_S;
            end
        end else begin
            if (pkt_done) begin
                state_d  = ARB_S;
                rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_S;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs are a pure pass-through of the granted requester while busy.
    always_comb begin
        dma_wr_req_out_valid = 1'b0;
        dma_wr_req_out_last  = 1'b0;
        dma_wr_req_out_head  = '0;
        dma_wr_req_out_data  = '0;
        dma_wr_req_out_src   = '0;
        arb_busy             = 1'b0;
        if (state_q == BUSY_S) begin
            dma_wr_req_out_valid = g_valid;
            dma_wr_req_out_last  = g_last;
            dma_wr_req_out_head  = g_head;
            dma_wr_req_out_data  = g_data;
            dma_wr_req_out_src   = grant_q;
            arb_busy             = 1'b1;
        end
    end

    always_comb begin
        dma_wr_req_in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dma_wr_req_in_ready[i] = (state_q == BUSY_S) && (grant_q == SRC_W'(i))
                                     && dma_wr_req_out_ready;
        end
    end

endmodule

// File: tb/tb_dma_wr_req_arbiter.sv
// Self-checking bench for dma_wr_req_arbiter: fixed vector table, directed
// packet scenarios, then randomized traffic against a packet-level model.
module tb_dma_wr_req_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   reqEnable;
    logic [N-1:0]   inValid;
    logic [N*128-1:0] inHead;
    logic [N*512-1:0] inData;
    logic [N-1:0]   inLast;
    logic [N-1:0]   inReady;
    logic           outValid;
    logic [127:0]   outHead;
    logic [511:0]   outData;
    logic           outLast;
    logic           outReady;
    logic [1:0]     outSrc;
    logic           arbBusy;

    dma_wr_req_arbiter #(.NUM_REQ(N), .SRC_W(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_enable           (reqEnable),
        .dma_wr_req_in_valid  (inValid),
        .dma_wr_req_in_head   (inHead),
        .dma_wr_req_in_data   (inData),
        .dma_wr_req_in_last   (inLast),
        .dma_wr_req_in_ready  (inReady),
        .dma_wr_req_out_valid (outValid),
        .dma_wr_req_out_head  (outHead),
        .dma_wr_req_out_data  (outData),
        .dma_wr_req_out_last  (outLast),
        .dma_wr_req_out_ready (outReady),
        .dma_wr_req_out_src   (outSrc),
        .arb_busy             (arbBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] valid;
        logic [3:0] last;
        logic       outReady;
        logic       expValid;
        logic       expLast;
        logic [1:0] expSrc;
        logic [3:0] expReady;
        logic       expBusy;
    } vec_t;

    vec_t table_v[20];

    // Packet-level reference: busy flag, granted index, next-start pointer.
    bit     mBusy;
    int     mGrant;
    int     mPtr;
    int     beatsDone[N];
    int     pktLen[N];
    int     grantQ[$];

    int     vectors = 0;
    int     miscompares = 0;
    int     readyMode = 0;
    bit     readyPhase = 1'b1;
    logic [N-1:0] validMask;

    function automatic vec_t mk(logic r, logic [3:0] en, logic [3:0] v, logic [3:0] l,
                                logic ordy, logic ev, logic el, logic [1:0] es,
                                logic [3:0] erdy, logic eb);
        vec_t t;
        t.rst = r; t.en = en; t.valid = v; t.last = l; t.outReady = ordy;
        t.expValid = ev; t.expLast = el; t.expSrc = es; t.expReady = erdy; t.expBusy = eb;
        return t;
    endfunction

    task automatic randomizeData();
        for (int i = 0; i < N*4; i++) inHead[32*i +: 32] = $urandom;
        for (int i = 0; i < N*16; i++) inData[32*i +: 32] = $urandom;
    endtask

    task automatic modelUpdate();
        logic [N-1:0] elig;
        bit found;
        int j;
        elig = inValid & reqEnable;
        found = 1'b0;
        if (rst) begin
            mBusy = 1'b0;
            mGrant = 0;
            mPtr = 0;
            for (int i = 0; i < N; i++) beatsDone[i] = 0;
        end else if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                j = (mPtr + k) % N;
                if (!found && elig[j]) begin
                    found = 1'b1;
                    mGrant = j;
                    mBusy = 1'b1;
                    grantQ.push_back(j);
                end
            end
        end else if (inValid[mGrant] && outReady) begin
            if (inLast[mGrant]) begin
                beatsDone[mGrant] = 0;
                mBusy = 1'b0;
                mPtr = (mGrant + 1) % N;
            end else begin
                beatsDone[mGrant] = beatsDone[mGrant] + 1;
            end
        end
    endtask

    task automatic checkOutput(input string name);
        logic         eValid, eLast, eBusy;
        logic [127:0] eHead;
        logic [511:0] eData;
        logic [1:0]   eSrc;
        logic [N-1:0] eReady;
        bit bad;
        bad = 1'b0;
        if (mBusy) begin
            eValid = inValid[mGrant];
            eLast  = inLast[mGrant];
            eHead  = inHead[128*mGrant +: 128];
            eData  = inData[512*mGrant +: 512];
            eSrc   = 2'(mGrant);
            eReady = outReady ? (4'b0001 << mGrant) : 4'b0000;
            eBusy  = 1'b1;
        end else begin
            eValid = 1'b0; eLast = 1'b0; eHead = '0; eData = '0;
            eSrc = '0; eReady = '0; eBusy = 1'b0;
        end
        if (outValid !== eValid) begin bad = 1'b1; $display("[TB] FAIL %s out_valid got %0b want %0b", name, outValid, eValid); end
        if (outLast !== eLast) begin bad = 1'b1; $display("[TB] FAIL %s out_last got %0b want %0b", name, outLast, eLast); end
        if (outSrc !== eSrc) begin bad = 1'b1; $display("[TB] FAIL %s out_src got %0d want %0d", name, outSrc, eSrc); end
        if (inReady !== eReady) begin bad = 1'b1; $display("[TB] FAIL %s in_ready got %b want %b", name, inReady, eReady); end
        if (arbBusy !== eBusy) begin bad = 1'b1; $display("[TB] FAIL %s arb_busy got %0b want %0b", name, arbBusy, eBusy); end
        if (outHead !== eHead) begin bad = 1'b1; $display("[TB] FAIL %s out_head got %h want %h", name, outHead, eHead); end
        if (outData !== eData) begin bad = 1'b1; $display("[TB] FAIL %s out_data got %h want %h", name, outData, eData); end
        vectors++;
        if (bad) miscompares++;
    endtask

    task automatic checkRow(input int r);
        vec_t t;
        logic [127:0] eHead;
        bit bad;
        t = table_v[r];
        bad = 1'b0;
        eHead = t.expBusy ? inHead[128*t.expSrc +: 128] : 128'd0;
        if (outValid !== t.expValid || outLast !== t.expLast || outSrc !== t.expSrc ||
            inReady !== t.expReady || arbBusy !== t.expBusy || outHead !== eHead) begin
            bad = 1'b1;
            $display("[TB] FAIL row%0d got v=%0b l=%0b src=%0d rdy=%b busy=%0b hdOk=%0b want v=%0b l=%0b src=%0d rdy=%b busy=%0b",
                     r, outValid, outLast, outSrc, inReady, arbBusy, (outHead === eHead),
                     t.expValid, t.expLast, t.expSrc, t.expReady, t.expBusy);
        end
        vectors++;
        if (bad) miscompares++;
    endtask

    task automatic step(input string name);
        #2;
        checkOutput(name);
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int r);
        rst       = table_v[r].rst;
        reqEnable = table_v[r].en;
        inValid   = table_v[r].valid;
        inLast    = table_v[r].last;
        outReady  = table_v[r].outReady;
        randomizeData();
    endtask

    task automatic trafficStep(input string name);
        for (int i = 0; i < N; i++) inLast[i] = (beatsDone[i] >= pktLen[i] - 1);
        inValid = validMask;
        case (readyMode)
            0: outReady = 1'b1;
            1: begin outReady = readyPhase; readyPhase = ~readyPhase; end
            default: outReady = 1'($urandom_range(0, 1));
        endcase
        randomizeData();
        step(name);
    endtask

    task automatic doReset();
        rst = 1'b1;
        validMask = '0;
        trafficStep("reset");
        rst = 1'b0;
        grantQ.delete();
    endtask

    task automatic waitGrants(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (grantQ.size() < n && c < budget) begin
            trafficStep(name);
            c++;
        end
        vectors++;
        if (grantQ.size() < n) begin
            $display("[TB] FAIL %s timeout grants got %0d want %0d", name, grantQ.size(), n);
            miscompares++;
        end
    endtask

    task automatic checkOrder(input string name, input int n, input int w[8]);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i >= grantQ.size()) begin
                bad = 1'b1;
                $display("[TB] FAIL %s grant[%0d] got none want %0d", name, i, w[i]);
            end else if (grantQ[i] != w[i]) begin
                bad = 1'b1;
                $display("[TB] FAIL %s grant[%0d] got %0d want %0d", name, i, grantQ[i], w[i]);
            end
        end
        vectors++;
        if (bad) miscompares++;
    endtask

    initial begin
        int w[8];
        table_v[0]  = mk(1, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[1]  = mk(0, 4'hF, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[2]  = mk(0, 4'hF, 4'b0100, 4'b0000, 1, 1, 0, 2, 4'b0100, 1);
        table_v[3]  = mk(0, 4'hF, 4'b0100, 4'b0000, 1, 1, 0, 2, 4'b0100, 1);
        table_v[4]  = mk(0, 4'hF, 4'b0100, 4'b0100, 1, 1, 1, 2, 4'b0100, 1);
        table_v[5]  = mk(0, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[6]  = mk(0, 4'hF, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
        table_v[7]  = mk(0, 4'hF, 4'b1111, 4'b1111, 1, 1, 1, 3, 4'b1000, 1);
        table_v[8]  = mk(0, 4'hF, 4'b0001, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
        table_v[9]  = mk(0, 4'hF, 4'b0001, 4'b0001, 1, 1, 1, 0, 4'b0001, 1);
        table_v[10] = mk(0, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[11] = mk(0, 4'hF, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[12] = mk(0, 4'hF, 4'b0010, 4'b0000, 0, 1, 0, 1, 4'b0000, 1);
        table_v[13] = mk(0, 4'hF, 4'b0010, 4'b0010, 0, 1, 1, 1, 4'b0000, 1);
        table_v[14] = mk(0, 4'hF, 4'b0010, 4'b0010, 1, 1, 1, 1, 4'b0010, 1);
        table_v[15] = mk(0, 4'h0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[16] = mk(0, 4'h0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        table_v[17] = mk(0, 4'h9, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 0);
        table_v[18] = mk(0, 4'h9, 4'b1111, 4'b1111, 1, 1, 1, 3, 4'b1000, 1);
        table_v[19] = mk(0, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);

        for (int i = 0; i < N; i++) begin beatsDone[i] = 0; pktLen[i] = 1; end
        mBusy = 1'b0; mGrant = 0; mPtr = 0;
        rst = 1'b1; reqEnable = '1; inValid = '0; inLast = '0; outReady = 1'b1;
        validMask = '0;
        randomizeData();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            applyStimulus(r);
            #2;
            checkRow(r);
            step($sformatf("row%0d_model", r));
        end

        // Round-robin fairness with 2-beat packets.
        doReset();
        reqEnable = '1; validMask = 4'b1111; readyMode = 0;
        for (int i = 0; i < N; i++) pktLen[i] = 2;
        waitGrants(5, 60, "rr");
        w = '{0, 1, 2, 3, 0, 0, 0, 0};
        checkOrder("rr_order", 5, w);

        // No interleave under toggling backpressure.
        doReset();
        validMask = 4'b0011; readyMode = 1; readyPhase = 1'b1;
        pktLen[0] = 4; pktLen[1] = 2;
        waitGrants(2, 40, "bp");
        w = '{0, 1, 0, 0, 0, 0, 0, 0};
        checkOrder("bp_order", 2, w);

        // Enable mask, then drop enable of req 1 during its packet.
        doReset();
        reqEnable = 4'b1010; validMask = 4'b1111; readyMode = 0;
        for (int i = 0; i < N; i++) pktLen[i] = 2;
        waitGrants(5, 60, "en");
        reqEnable = 4'b1000;
        waitGrants(7, 60, "en_clr");
        w = '{1, 3, 1, 3, 1, 3, 3, 0};
        checkOrder("en_order", 7, w);

        // Requester stall mid-packet, then a single-beat packet.
        doReset();
        reqEnable = '1; validMask = 4'b1000; readyMode = 0;
        pktLen[3] = 3; pktLen[0] = 2;
        waitGrants(1, 10, "stall");
        trafficStep("stall_beat1");
        validMask = 4'b0001;
        for (int i = 0; i < 5; i++) trafficStep("stall_gap");
        validMask = 4'b1001;
        waitGrants(2, 30, "stall_resume");
        pktLen[3] = 1;
        waitGrants(4, 30, "single");
        w = '{3, 0, 3, 0, 0, 0, 0, 0};
        checkOrder("stall_order", 4, w);

        // Reset during beat 2 of a 4-beat packet from req 1.
        doReset();
        validMask = 4'b1111;
        for (int i = 0; i < N; i++) pktLen[i] = 4;
        waitGrants(2, 30, "rstmid");
        trafficStep("rstmid_beat1");
        rst = 1'b1;
        trafficStep("rstmid_assert");
        rst = 1'b0;
        grantQ.delete();
        waitGrants(1, 10, "rstmid_after");
        w = '{0, 0, 0, 0, 0, 0, 0, 0};
        checkOrder("rstmid_order", 1, w);

        // Randomized traffic, occasional reset.
        doReset();
        readyMode = 2;
        for (int c = 0; c < 3000; c++) begin
            validMask = 4'($urandom);
            reqEnable = 4'($urandom | $urandom);
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                if (beatsDone[i] == 0) pktLen[i] = $urandom_range(1, 4);
            trafficStep("rand");
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dma_wr_req_arbiter.md
# dma_wr_req_arbiter

Packet-granular round-robin arbiter that shares one 512-bit DMA write request channel between `NUM_REQ` independent requesters (QP engines, CQ/EQ writers, etc.). It sits directly upstream of the 512-to-256 DMA write width converter. It locks the grant to one requester from the first beat to the `last` beat, so a packet's header and data are never interleaved with another source. It reports the granted source index so downstream logic can attribute the transfer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SRC_W`, 2: width of the source index, equal to clog2(`NUM_REQ`).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_enable`  in  NUM_REQ  per-requester arbitration enable (configuration); sampled only when arbitrating.
- `dma_wr_req_in_valid`  in  NUM_REQ  per-requester valid.
- `dma_wr_req_in_head`  in  NUM_REQ*128  flattened headers; requester i at [128*i+127:128*i]; head[31:0] is byte length.
- `dma_wr_req_in_data`  in  NUM_REQ*512  flattened data, requester i at [512*i+511:512*i].
- `dma_wr_req_in_last`  in  NUM_REQ  per-requester last beat.
- `dma_wr_req_in_ready`  out  NUM_REQ  per-requester ready.
- `dma_wr_req_out_valid`  out  1  to width converter.
- `dma_wr_req_out_head`  out  128  header of the granted requester.
- `dma_wr_req_out_data`  out  512  data of the granted requester.
- `dma_wr_req_out_last`  out  1  last beat of the granted requester.
- `dma_wr_req_out_ready`  in  1  from width converter.
- `dma_wr_req_out_src`  out  SRC_W  index of the granted requester; valid while `dma_wr_req_out_valid`=1.
- `arb_busy`  out  1  high in BUSY_s.

## Operation
- State machine:
  - ARB_s: no grant. All `in_ready`=0, `out_valid`=0, `out_head`/`out_data`/`out_last`=0.
    - Eligible set is `in_valid & req_enable`.
    - If the set is non-empty, select the first eligible index scanning rr_ptr, rr_ptr+1, … mod `NUM_REQ`.
    - Register the selection into grant and go to BUSY_s. Otherwise stay in ARB_s.
  - BUSY_s: pure combinational pass-through of requester g = grant.
    - `out_valid` = `in_valid[g]`; `out_head`/`out_data`/`out_last` = requester g fields.
    - `in_ready[g]` = `out_ready`; all other `in_ready` = 0.
    - `out_src` = g.
    - On handshake (`in_valid[g]` & `out_ready` & `in_last[g]`): go to ARB_s and set rr_ptr to (g+1) mod `NUM_REQ`.
- rr_ptr wrap: g = `NUM_REQ`-1 sets rr_ptr to 0.
- Grant is held for the whole packet:
  - If requester g drops valid mid-packet, the arbiter waits indefinitely in BUSY_s (no timeout, no preemption).
  - Deasserting `req_enable[g]` mid-packet does not abort the packet; it only excludes g from later arbitration.
- Non-granted requesters never see ready; their valid/data may change freely without effect.
- Single-beat packets (`last` on the first beat) are legal: BUSY_s lasts exactly one handshake.
- The arbiter never inspects the length field; `last` alone delimits packets.
- Reset:
  - State = ARB_s, rr_ptr = 0, grant = 0.
  - All outputs 0: `out_valid`, `out_last`, `out_head`, `out_data`, `out_src`, `in_ready`, `arb_busy`.
  - Reset asserted mid-packet discards the packet: the next cycle is ARB_s with no grant, and the downstream converter is reset by the same `rst`.

## Timing
- Arbitration latency is 1 cycle:
  - Requester i raises valid in cycle t while in ARB_s.
  - Grant registers at the t+1 edge; the first beat is presented and can transfer in cycle t+1.
- Inter-packet gap is 1 cycle:
  - The last-beat handshake in cycle k puts the block in ARB_s in cycle k+1.
  - The next grant's first beat can transfer in cycle k+2.
  - Maximum throughput is N beats per N+1 cycles per packet.
- Ready path is combinational: `in_ready[g]` follows `out_ready` in the same cycle. Valid/data path is combinational.
- Simultaneous events: if a requester asserts valid in the same cycle the current packet's last beat completes, it is seen in the following ARB_s cycle using the updated rr_ptr.
- Backpressure: with `out_ready`=0, all outputs hold the granted requester's current inputs. The requester must hold them stable per valid/ready rules.

## Test plan
- Single requester: only req 2 valid with a 3-beat packet, `out_ready`=1, rr_ptr=0.
  - Expect grant at cycle 1, `out_src`=2, beats transfer in cycles 1-3 with `out_last` in cycle 3.
  - Expect ARB_s in cycle 4 and rr_ptr=3.
- Round-robin fairness: all 4 requesters continuously valid with 2-beat packets.
  - Expect grant order 0,1,2,3,0, with exactly 1 idle cycle (`out_valid`=0) between packets.
- No interleave under backpressure: req 0 sends 4 beats while req 1 is valid throughout; toggle `out_ready` 1,0,1,0.
  - Expect `in_ready[1]`=0 until req 0's last handshake; req 1 is granted 1 cycle later.
- Enable mask: `req_enable`=4'b1010, all valid.
  - Expect grants only 1,3,1,3.
  - Clear `req_enable[1]` mid-packet: req 1's packet still completes, then only 3 is granted.
- Requester stall: req 3 is granted, then drops valid for 5 cycles mid-packet while req 0 is valid.
  - Expect the grant to stay on 3 with `out_valid`=0 and `in_ready[0]`=0 until req 3 finishes.
  - Also cover a single-beat packet on req 3 (last on first beat).
- Reset mid-packet: assert `rst` during beat 2 of 4.
  - Expect all outputs 0 in the next cycle, rr_ptr=0.
  - With all requesters then valid, the first grant after reset is to req 0.
